// File: rtl/fu_arith_pipe.sv
// fu_arith_pipe: pipelined AArch64 integer add/sub functional unit.
//
// Decodes ADD/ADDS/SUB/SUBS (immediate and shifted-register with zero shift),
// CMP/CMN (flag-setting forms with Rd=31) and ADC/SBC, computes the Rd result
// and NZCV in slot 0, then carries the result through STAGES registered slots
// with valid/ready back-pressure. Empty slots are refilled from upstream so
// bubbles collapse.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-low reset
//   i_inst_valid          issue request
//   o_fu_ready            slot 0 can load this cycle (combinational from i_out_ready)
//   i_inst, i_inst_id     raw instruction word, ROB id
//   i_op0, i_op1          Xn, Xm (Xm ignored for immediate forms)
//   i_nzcv_in             current flags {N,Z,C,V}; C feeds ADC/SBC
//   i_prn_rd, i_prn_flags destination PRNs for Rd and flags
//   o_out_valid           result available; i_out_ready pops it
//   o_out_data(_valid)    Rd result and its write enable
//   o_out_nzcv(_valid)    flags and their write enable
//   o_out_prn_rd, o_out_prn_flags, o_out_inst_id  carried tags
//   o_out_illegal         instruction did not decode
//
// Optional feature (macro FU_ARITH_PIPE_FLUSH_EN): adds i_flush/i_flush_id;
// every slot, and any instruction accepted that cycle, whose id is younger
// than or equal to i_flush_id is squashed.
module fu_arith_pipe #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned STAGES = 2,
    parameter int unsigned PRN_W  = 7,
    parameter int unsigned ID_W   = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inst_valid,
    output logic             o_fu_ready,
    input  logic [31:0]      i_inst,
    input  logic [ID_W-1:0]  i_inst_id,
    input  logic [XLEN-1:0]  i_op0,
    input  logic [XLEN-1:0]  i_op1,
    input  logic [3:0]       i_nzcv_in,
    input  logic [PRN_W-1:0] i_prn_rd,
    input  logic [PRN_W-1:0] i_prn_flags,
`ifdef FU_ARITH_PIPE_FLUSH_EN
    input  logic             i_flush,
    input  logic [ID_W-1:0]  i_flush_id,
`endif
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [XLEN-1:0]  o_out_data,
    output logic             o_out_data_valid,
    output logic [3:0]       o_out_nzcv,
    output logic             o_out_nzcv_valid,
    output logic [PRN_W-1:0] o_out_prn_rd,
    output logic [PRN_W-1:0] o_out_prn_flags,
    output logic [ID_W-1:0]  o_out_inst_id,
    output logic             o_out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic             data_valid;
        logic [3:0]       nzcv;
        logic             nzcv_valid;
        logic [PRN_W-1:0] prn_rd;
        logic [PRN_W-1:0] prn_flags;
        logic [ID_W-1:0]  inst_id;
        logic             illegal;
    } slot_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic w_legal;
    logic w_imm_form;
    logic w_is_sub;
    logic w_use_c;
    logic w_set_flags;

    always_comb begin
        w_legal     = 1'b0;
        w_imm_form  = 1'b0;
        w_is_sub    = 1'b0;
        w_use_c     = 1'b0;
        w_set_flags = 1'b0;
        case (i_inst[31:23])
            9'b100100010: begin w_legal = 1'b1; w_imm_form = 1'b1; end
            9'b101100010: begin w_legal = 1'b1; w_imm_form = 1'b1; w_set_flags = 1'b1; end
            9'b110100010: begin w_legal = 1'b1; w_imm_form = 1'b1; w_is_sub = 1'b1; end
            9'b111100010: begin
                w_legal     = 1'b1;
                w_imm_form  = 1'b1;
                w_is_sub    = 1'b1;
                w_set_flags = 1'b1;
            end
            default: ;
        endcase
        // Register forms only decode with a zero shift amount / zero opcode2.
        if (!w_imm_form && (i_inst[15:10] == 6'd0)) begin
            case (i_inst[31:21])
                11'b10001011000: w_legal = 1'b1;
                11'b10101011000: begin w_legal = 1'b1; w_set_flags = 1'b1; end
                11'b11001011000: begin w_legal = 1'b1; w_is_sub = 1'b1; end
                11'b11101011000: begin
                    w_legal     = 1'b1;
                    w_is_sub    = 1'b1;
                    w_set_flags = 1'b1;
                end
                11'b10011010000: begin w_legal = 1'b1; w_use_c = 1'b1; end
                11'b11011010000: begin w_legal = 1'b1; w_use_c = 1'b1; w_is_sub = 1'b1; end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: {c,s} = a + b' + cin
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_bx;
    logic            w_cin;
    logic [XLEN:0]   w_sum;
    logic [XLEN-1:0] w_s;
    logic [3:0]      w_nzcv;
    slot_t           w_issue;

    assign w_imm  = i_inst[22] ? (XLEN'(i_inst[21:10]) << 12) : XLEN'(i_inst[21:10]);
    assign w_b    = w_imm_form ? w_imm : i_op1;
    assign w_bx   = w_is_sub ? ~w_b : w_b;
    assign w_cin  = w_use_c ? i_nzcv_in[1] : w_is_sub;
    assign w_sum  = {1'b0, i_op0} + {1'b0, w_bx} + {{XLEN{1'b0}}, w_cin};
    assign w_s    = w_sum[XLEN-1:0];
    assign w_nzcv = {w_s[XLEN-1],
                     (w_s == '0),
                     w_sum[XLEN],
                     (i_op0[XLEN-1] == w_bx[XLEN-1]) && (w_s[XLEN-1] != i_op0[XLEN-1])};

    always_comb begin
        w_issue            = '0;
        w_issue.data       = w_s;
        w_issue.nzcv       = w_nzcv;
        w_issue.nzcv_valid = w_legal && w_set_flags;
        // CMP/CMN: flag-setting forms targeting XZR do not write Rd.
        w_issue.data_valid = w_legal && !(w_set_flags && (i_inst[4:0] == 5'h1f));
        w_issue.prn_rd     = i_prn_rd;
        w_issue.prn_flags  = i_prn_flags;
        w_issue.inst_id    = i_inst_id;
        w_issue.illegal    = !w_legal;
    end

    // ------------------------------------------------------------------
    // Pipeline slots
    // ------------------------------------------------------------------
    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_load;
    slot_t             w_slot [STAGES];

    // A slot loads if it, or any slot downstream of it, is empty, or if the
    // last slot is being popped; walking from the tail avoids a comb chain.
    always_comb begin : p_load
        logic v_acc;
        v_acc  = !w_valid[STAGES-1] || i_out_ready;
        w_load = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            v_acc     = v_acc || !w_valid[k];
            w_load[k] = v_acc;
        end
    end

    assign o_fu_ready = i_rst && w_load[0];

`ifdef FU_ARITH_PIPE_FLUSH_EN
    // Younger-or-equal in ROB-wrap order: id lies within the half window at
    // or after flush_id.
    function automatic logic younger_eq(input logic [ID_W-1:0] id,
                                        input logic [ID_W-1:0] fid);
        logic [ID_W-1:0] d;
        d = id - fid;
        return !d[ID_W-1];
    endfunction
`endif

    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        logic  w_in_valid;
        slot_t w_in;
        logic  w_kill_in;
        logic  w_kill_hold;
        logic  r_valid;
        slot_t r_slot;

        if (g == 0) begin : g_head
            assign w_in_valid = i_inst_valid && o_fu_ready;
            assign w_in       = w_issue;
        end else begin : g_body
            assign w_in_valid = w_valid[g-1];
            assign w_in       = w_slot[g-1];
        end

`ifdef FU_ARITH_PIPE_FLUSH_EN
        assign w_kill_in   = i_flush && younger_eq(w_in.inst_id, i_flush_id);
        assign w_kill_hold = i_flush && younger_eq(r_slot.inst_id, i_flush_id);
`else
        assign w_kill_in   = 1'b0;
        assign w_kill_hold = 1'b0;
`endif

        always_ff @(posedge i_clk) begin
            if (!i_rst) begin
                r_valid <= 1'b0;
                r_slot  <= '0;
            end else if (w_load[g]) begin
                r_valid <= w_in_valid && !w_kill_in;
                // Payload only moves with a real instruction so outputs hold
                // their last value across bubbles.
                if (w_in_valid) begin
                    r_slot <= w_in;
                end
            end else begin
                r_valid <= r_valid && !w_kill_hold;
            end
        end

        assign w_valid[g] = r_valid;
        assign w_slot[g]  = r_slot;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_out_valid      = w_valid[STAGES-1];
    assign o_out_data       = w_slot[STAGES-1].data;
    assign o_out_data_valid = w_slot[STAGES-1].data_valid;
    assign o_out_nzcv       = w_slot[STAGES-1].nzcv;
    assign o_out_nzcv_valid = w_slot[STAGES-1].nzcv_valid;
    assign o_out_prn_rd     = w_slot[STAGES-1].prn_rd;
    assign o_out_prn_flags  = w_slot[STAGES-1].prn_flags;
    assign o_out_inst_id    = w_slot[STAGES-1].inst_id;
    assign o_out_illegal    = w_slot[STAGES-1].illegal;

    // Register/Rn fields and the N/Z/V input flags are not needed here.
    logic w_unused;
    assign w_unused = ^{i_inst[20:16], i_inst[9:5], i_nzcv_in[3:2], i_nzcv_in[0]};

endmodule

// File: tb/tb_fu_arith_pipe.sv
// tb_fu_arith_pipe: scoreboard bench for fu_arith_pipe (XLEN=64, STAGES=2).
// Expected results come from a behavioural model (signed/unsigned big-integer
// arithmetic) and are queued at accept time; a monitor pops and compares on
// every output handshake and checks outputs hold while stalled.
module tb_fu_arith_pipe;

    localparam int XLEN   = 64;
    localparam int STAGES = 2;
    localparam int PRN_W  = 7;
    localparam int ID_W   = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             inst_valid;
    logic             fu_ready;
    logic [31:0]      inst;
    logic [ID_W-1:0]  inst_id;
    logic [XLEN-1:0]  op0, op1;
    logic [3:0]       nzcv_in;
    logic [PRN_W-1:0] prn_rd, prn_flags;
    logic             out_valid, out_ready;
    logic [XLEN-1:0]  out_data;
    logic             out_data_valid;
    logic [3:0]       out_nzcv;
    logic             out_nzcv_valid;
    logic [PRN_W-1:0] out_prn_rd, out_prn_flags;
    logic [ID_W-1:0]  out_inst_id;
    logic             out_illegal;
`ifdef FU_ARITH_PIPE_FLUSH_EN
    logic             flush;
    logic [ID_W-1:0]  flush_id;
`endif

    fu_arith_pipe #(.XLEN(XLEN), .STAGES(STAGES), .PRN_W(PRN_W), .ID_W(ID_W)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_inst_valid     (inst_valid),
        .o_fu_ready       (fu_ready),
        .i_inst           (inst),
        .i_inst_id        (inst_id),
        .i_op0            (op0),
        .i_op1            (op1),
        .i_nzcv_in        (nzcv_in),
        .i_prn_rd         (prn_rd),
        .i_prn_flags      (prn_flags),
`ifdef FU_ARITH_PIPE_FLUSH_EN
        .i_flush          (flush),
        .i_flush_id       (flush_id),
`endif
        .o_out_valid      (out_valid),
        .i_out_ready      (out_ready),
        .o_out_data       (out_data),
        .o_out_data_valid (out_data_valid),
        .o_out_nzcv       (out_nzcv),
        .o_out_nzcv_valid (out_nzcv_valid),
        .o_out_prn_rd     (out_prn_rd),
        .o_out_prn_flags  (out_prn_flags),
        .o_out_inst_id    (out_inst_id),
        .o_out_illegal    (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        bit          dv;
        logic [3:0]  nzcv;
        bit          nv;
        bit          ill;
        logic [6:0]  prd;
        logic [6:0]  pfl;
        logic [5:0]  id;
        bit          chk_lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    wire [90:0] outs = {out_data, out_data_valid, out_nzcv, out_nzcv_valid,
                        out_prn_rd, out_prn_flags, out_inst_id, out_illegal};

    function automatic exp_t mk(input logic [63:0] d, input bit dv, input logic [3:0] n,
                                input bit nv, input bit ill);
        exp_t e;
        e = '{default: 0};
        e.data = d; e.dv = dv; e.nzcv = n; e.nv = nv; e.ill = ill;
        return e;
    endfunction

    // Reference model: kind 0=add 1=sub 2=adc 3=sbc, -1=undecoded.
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] a,
                                   input logic [63:0] m, input logic [3:0] f);
        exp_t             e;
        int               kind;
        bit               setf;
        bit               c;
        bit               cy;
        logic [63:0]      b;
        logic [63:0]      s;
        logic [65:0]      ur;
        logic signed [65:0] sa, sb_, sr;
        e = '{default: 0};
        kind = -1; setf = 0; b = m;
        case (ins[31:23])
            9'b100100010: kind = 0;
            9'b101100010: begin kind = 0; setf = 1; end
            9'b110100010: kind = 1;
            9'b111100010: begin kind = 1; setf = 1; end
            default: ;
        endcase
        if (kind >= 0) begin
            b = ins[22] ? {40'd0, ins[21:10], 12'd0} : {52'd0, ins[21:10]};
        end else if (ins[15:10] == 6'd0) begin
            case (ins[31:21])
                11'b10001011000: kind = 0;
                11'b10101011000: begin kind = 0; setf = 1; end
                11'b11001011000: kind = 1;
                11'b11101011000: begin kind = 1; setf = 1; end
                11'b10011010000: kind = 2;
                11'b11011010000: kind = 3;
                default: ;
            endcase
        end
        if (kind < 0) begin
            e.ill = 1;
            return e;
        end
        cy  = (kind == 2) ? f[1] : ((kind == 3) ? !f[1] : 1'b0);
        sa  = $signed({{2{a[63]}}, a});
        sb_ = $signed({{2{b[63]}}, b});
        if (kind == 0 || kind == 2) begin
            ur = {2'b00, a} + {2'b00, b} + {65'd0, cy};
            c  = ur[64];
            sr = sa + sb_ + (cy ? 66'sd1 : 66'sd0);
        end else begin
            // cy is the borrow here; carry means no borrow.
            c  = ({2'b00, a} >= ({2'b00, b} + {65'd0, cy}));
            sr = sa - sb_ - (cy ? 66'sd1 : 66'sd0);
        end
        s      = sr[63:0];
        e.data = s;
        e.nzcv = {s[63], (s == 64'd0), c, !(sr[65:63] == 3'b000 || sr[65:63] == 3'b111)};
        e.nv   = setf;
        e.dv   = !(setf && ins[4:0] == 5'h1f);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_out(input exp_t e);
        bit ok;
        checks++;
        ok = (out_illegal === e.ill) && (out_data_valid === e.dv) && (out_nzcv_valid === e.nv)
             && (out_prn_rd === e.prd) && (out_prn_flags === e.pfl) && (out_inst_id === e.id)
             && (!e.dv || out_data === e.data) && (!e.nv || out_nzcv === e.nzcv);
        if (!ok) begin
            errors++;
            $display("FAIL result id=%0d: got data=%h dv=%b nzcv=%b nv=%b ill=%b prd=%0d pfl=%0d id=%0d; expected data=%h dv=%b nzcv=%b nv=%b ill=%b prd=%0d pfl=%0d",
                     e.id, out_data, out_data_valid, out_nzcv, out_nzcv_valid, out_illegal,
                     out_prn_rd, out_prn_flags, out_inst_id, e.data, e.dv, e.nzcv, e.nv, e.ill,
                     e.prd, e.pfl);
        end
        if (e.chk_lat) chk("latency", 64'(cyc - e.acc_cyc), 64'(STAGES));
    endtask

    initial forever @(posedge clk) cyc++;

    // Monitor: pop on handshake; outputs must hold while stalled.
    initial begin : monitor
        bit         was_stall;
        logic [90:0] snap;
        exp_t       e;
        was_stall = 0;
        snap      = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                was_stall = 0;
            end else begin
                if (was_stall) begin
                    checks++;
                    if (outs !== snap || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall-hold: got valid=%b outs=%h, expected valid=1 outs=%h",
                                 out_valid, outs, snap);
                    end
                end
                if (out_valid && out_ready) begin
                    pop_cyc.push_back(cyc);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected output: got id=%0d, expected none", out_inst_id);
                    end else begin
                        e = sb.pop_front();
                        check_out(e);
                    end
                end
                was_stall = out_valid && !out_ready;
                snap      = outs;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic drive_op(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                            input logic [3:0] f, input logic [6:0] prd, input logic [6:0] pfl,
                            input logic [5:0] id, input exp_t e, input bit lat);
        inst = ins; op0 = a; op1 = b; nzcv_in = f;
        prn_rd = prd; prn_flags = pfl; inst_id = id;
        inst_valid = 1'b1;
        e.prd = prd; e.pfl = pfl; e.id = id; e.chk_lat = lat;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (fu_ready) begin
                e.acc_cyc = cyc;
                sb.push_back(e);
                @(posedge clk);
                #1;
                inst_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL accept timeout id=%0d: got fu_ready=0, expected 1", id);
        inst_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain timeout: got %0d pending, expected 0", sb.size());
        end
    endtask

    function automatic logic [31:0] enc_imm(input logic [8:0] opc, input bit sh,
                                            input logic [11:0] imm, input logic [4:0] rd);
        return {opc, sh, imm, 5'd3, rd};
    endfunction

    function automatic logic [31:0] enc_reg(input logic [10:0] opc, input logic [5:0] imm6,
                                            input logic [4:0] rd);
        return {opc, 5'd7, imm6, 5'd3, rd};
    endfunction

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            4: return 64'h8000_0000_0000_0000;
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [4:0]  rd;
        logic [11:0] imm;
        bit          sh;
        rd  = ($urandom_range(0, 3) == 0) ? 5'h1f : 5'($urandom);
        imm = 12'($urandom);
        sh  = 1'($urandom);
        case ($urandom_range(0, 11))
            0:  return enc_imm(9'b100100010, sh, imm, rd);
            1:  return enc_imm(9'b101100010, sh, imm, rd);
            2:  return enc_imm(9'b110100010, sh, imm, rd);
            3:  return enc_imm(9'b111100010, sh, imm, rd);
            4:  return enc_reg(11'b10001011000, 6'd0, rd);
            5:  return enc_reg(11'b10101011000, 6'd0, rd);
            6:  return enc_reg(11'b11001011000, 6'd0, rd);
            7:  return enc_reg(11'b11101011000, 6'd0, rd);
            8:  return enc_reg(11'b10011010000, 6'd0, rd);
            9:  return enc_reg(11'b11011010000, 6'd0, rd);
            10: return enc_reg(11'b11101011000, 6'($urandom_range(1, 63)), rd);
            default: return {1'b0, 31'($urandom)};
        endcase
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    bit rnd_run = 0;

    initial begin : main
        logic [31:0] ins;
        logic [63:0] a, b;
        logic [3:0]  f;
        logic [5:0]  id;
        exp_t        e;
        int          acc;

        rst = 1'b0; inst_valid = 1'b0; inst = '0; inst_id = '0; op0 = '0; op1 = '0;
        nzcv_in = '0; prn_rd = '0; prn_flags = '0; out_ready = 1'b1;
`ifdef FU_ARITH_PIPE_FLUSH_EN
        flush = 1'b0; flush_id = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset fu_ready", 64'(fu_ready), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_data", out_data, 64'd0);
        chk("reset out_nzcv", 64'(out_nzcv), 64'd0);
        chk("reset out_illegal", 64'(out_illegal), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("fu_ready after release", 64'(fu_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed: ADDS overflow, CMP equal/less, ADD sh=1 to XZR, SBC with C=0.
        drive_op(enc_imm(9'b101100010, 1'b0, 12'd1, 5'd1), 64'h7FFF_FFFF_FFFF_FFFF, 64'd0,
                 4'b0000, 7'd10, 7'd70, 6'd1,
                 mk(64'h8000_0000_0000_0000, 1, 4'b1001, 1, 0), 1);
        wait_drain();
        drive_op(enc_reg(11'b11101011000, 6'd0, 5'h1f), 64'd5, 64'd5, 4'b0000, 7'd11, 7'd71,
                 6'd2, mk(64'd0, 0, 4'b0110, 1, 0), 1);
        drive_op(enc_reg(11'b11101011000, 6'd0, 5'h1f), 64'd3, 64'd5, 4'b0000, 7'd12, 7'd72,
                 6'd3, mk(64'd0, 0, 4'b1000, 1, 0), 1);
        drive_op(enc_imm(9'b100100010, 1'b1, 12'd1, 5'h1f), 64'h10, 64'd0, 4'b1111, 7'd13,
                 7'd73, 6'd4, mk(64'h1010, 1, 4'b0000, 0, 0), 1);
        drive_op(enc_reg(11'b11011010000, 6'd0, 5'd4), 64'd10, 64'd3, 4'b0000, 7'd14, 7'd74,
                 6'd5, mk(64'd6, 1, 4'b0000, 0, 0), 1);
        drive_op(32'h0000_0000, 64'd1, 64'd2, 4'b0000, 7'd15, 7'd75, 6'd6,
                 mk(64'd0, 0, 4'b0000, 0, 1), 1);
        wait_drain();

        // Back-pressure: 4 back-to-back issues while out_ready=0 for 5 cycles.
        out_ready = 1'b0;
        pop_cyc.delete();
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            a = rnd_val(); b = rnd_val();
            ins = enc_reg(11'b10001011000, 6'd0, 5'(i + 1));
            inst = ins; op0 = a; op1 = b; nzcv_in = 4'b0;
            prn_rd = 7'(20 + i); prn_flags = 7'(90 + i); inst_id = 6'(10 + i);
            inst_valid = 1'b1;
            @(negedge clk);
            chk("fu_ready under stall", 64'(fu_ready), (acc < STAGES) ? 64'd1 : 64'd0);
            if (fu_ready) begin
                e = model(ins, a, b, 4'b0);
                e.prd = prn_rd; e.pfl = prn_flags; e.id = inst_id; e.chk_lat = 0;
                sb.push_back(e);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        inst_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = acc; i < 4; i++) begin
            a = rnd_val(); b = rnd_val();
            ins = enc_reg(11'b10001011000, 6'd0, 5'(i + 1));
            drive_op(ins, a, b, 4'b0, 7'(20 + i), 7'(90 + i), 6'(10 + i), model(ins, a, b, 4'b0), 0);
        end
        wait_drain();
        chk("burst pop count", 64'(pop_cyc.size()), 64'd4);
        if (pop_cyc.size() == 4) chk("burst one per cycle", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);

        // Reset with two instructions in flight.
        out_ready = 1'b0;
        drive_op(enc_reg(11'b10001011000, 6'd0, 5'd1), 64'd1, 64'd2, 4'b0, 7'd1, 7'd2, 6'd20,
                 mk(64'd3, 1, 4'b0, 0, 0), 0);
        drive_op(enc_reg(11'b10001011000, 6'd0, 5'd1), 64'd4, 64'd5, 4'b0, 7'd1, 7'd2, 6'd21,
                 mk(64'd9, 1, 4'b0, 0, 0), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("fu_ready in reset", 64'(fu_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("out_valid after reset", 64'(out_valid), 64'd0);
        chk("out_data after reset", out_data, 64'd0);
        chk("out_inst_id after reset", 64'(out_inst_id), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("fu_ready first cycle after reset", 64'(fu_ready), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("nothing emerges after reset", 64'(out_valid), 64'd0);

        // Randomised traffic with random back-pressure.
        rnd_run = 1;
        fork
            while (rnd_run) begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 9) < 7);
            end
        join_none
        id = 6'd30;
        for (int n = 0; n < 300; n++) begin
            ins = rnd_inst(); a = rnd_val(); b = rnd_val(); f = 4'($urandom);
            drive_op(ins, a, b, f, 7'($urandom), 7'($urandom), id, model(ins, a, b, f), 0);
            id++;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_run = 0;
        repeat (2) @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain();

`ifdef FU_ARITH_PIPE_FLUSH_EN
        // ids 3,4,5 issued; flush at id 4 in the cycle id 5 is presented.
        ins = enc_reg(11'b10001011000, 6'd0, 5'd1);
        drive_op(ins, 64'd7, 64'd8, 4'b0, 7'd3, 7'd3, 6'd3, mk(64'd15, 1, 4'b0, 0, 0), 0);
        inst_id = 6'd4; inst_valid = 1'b1;
        @(posedge clk);
        #1;
        inst_id = 6'd5; flush = 1'b1; flush_id = 6'd4;
        @(negedge clk);
        chk("fu_ready during flush", 64'(fu_ready), 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b0; inst_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("flush leaves pipe empty", 64'(out_valid), 64'd0);
`endif

        wait_drain();
        chk("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fu_arith_pipe.md
Name: fu_arith_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle integer add/sub functional unit in the out-of-order core's execute cluster.
- Decodes AArch64 ADD/SUB/ADDS/SUBS/CMP/CMN in immediate and register forms, plus ADC/SBC.
- Produces the Rd result and NZCV flags with correct ARM carry/overflow semantics.
- Uses a STAGES-deep valid/ready pipeline with downstream back-pressure toward the writeback/CDB arbiter.

Parameters:
- XLEN, 64, datapath width in bits (32 or 64).
- STAGES, 2, pipeline depth in cycles, legal 1..4.
- PRN_W, 7, physical register number width.
- ID_W, 6, ROB instruction-id width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- inst_valid  in  1  issue request.
- fu_ready  out  1  unit accepts an instruction this cycle.
- inst  in  32  raw instruction word.
- inst_id  in  ID_W  ROB id of the instruction.
- op0  in  XLEN  Xn value.
- op1  in  XLEN  Xm value; ignored for immediate forms.
- nzcv_in  in  4  current flags; C is used by ADC/SBC.
- prn_rd  in  PRN_W  destination PRN for Rd.
- prn_flags  in  PRN_W  destination PRN for flags.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  XLEN  Rd result.
- out_data_valid  out  1  Rd is written.
- out_nzcv  out  4  {N,Z,C,V}.
- out_nzcv_valid  out  1  flags are written.
- out_prn_rd  out  PRN_W  Rd PRN.
- out_prn_flags  out  PRN_W  flags PRN.
- out_inst_id  out  ID_W  ROB id.
- out_illegal  out  1  instruction was not decoded.

Behaviour:
- Decode
  - Immediate forms match inst[31:23]: ADD 100100010, ADDS 101100010, SUB 110100010, SUBS 111100010.
  - Immediate operand: b = zero-extended imm12 = inst[21:10], shifted left 12 when inst[22]=1.
  - Register forms match inst[31:21] with inst[15:10]=0: ADD 10001011000, ADDS 10101011000, SUB 11001011000, SUBS 11101011000, ADC 10011010000, SBC 11011010000.
- Arithmetic: {c,s} = a + b' + cin, computed at XLEN+1 bits.
  - Add: b' = b, cin = 0.
  - Sub: b' = ~b, cin = 1.
  - ADC: b' = b, cin = nzcv_in.C.
  - SBC: b' = ~b, cin = nzcv_in.C.
- Flags:
  - N = s[XLEN-1].
  - Z = (s == 0).
  - C = carry-out, so for subtract C=1 means no borrow.
  - V = (a[XLEN-1] == b'[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]).
- Write enables:
  - out_nzcv_valid = 1 only for ADDS/SUBS. ADC/SBC do not set flags.
  - out_data_valid = 1 unless the op is flag-setting with inst[4:0]=11111 (CMP/CMN). Non-flag-setting ops always write Rd.
- Undecoded instruction: accepted normally, retires with out_illegal=1 and both write enables 0, so the ROB can fault it.
- Pipeline
  - STAGES registered slots, each with its own valid bit; all arithmetic completes in slot 0.
  - Slot k loads when it is empty, or when slot k+1 loads that cycle (last slot: out_valid && out_ready).
  - fu_ready = slot 0 can load; this is combinational from out_ready.
  - Bubbles collapse.
  - Latency is exactly STAGES cycles from accept to out_valid when out_ready=1.
  - Throughput is 1 per cycle.
- Handshake
  - Accept happens when inst_valid && fu_ready.
  - While out_valid && !out_ready, all out_* signals hold stable.
  - inst_valid with fu_ready=0 is ignored; the issuer retries.
- Reset (rst=0 at posedge)
  - All valid bits clear and all out_* clear to 0.
  - fu_ready = 0 while rst=0; it is 1 in the first cycle after release.
  - Reset mid-operation discards in-flight instructions.
- Simultaneous accept and pop on a full pipeline is legal; occupancy is unchanged.
- Width rule: for XLEN=32, inst[31] is still required to be 1 for a decode match; the datapath is simply narrower. This mode is intended for the 32-bit test configuration only.

Optional Feature:
- Macro FU_ARITH_PIPE_FLUSH_EN.
- With the macro defined:
  - Adds inputs flush (1) and flush_id (ID_W).
  - A slot whose inst_id is younger than or equal to flush_id in ROB-wrap order has its valid bit cleared at the same posedge.
  - An instruction accepted in that same cycle is also squashed.
- Without the macro: no ports are added; in-flight instructions complete normally.

Test Plan:
- XLEN=64, STAGES=2. ADDS imm: op0=0x7FFF_FFFF_FFFF_FFFF, imm12=1 -> after 2 cycles out_data=0x8000_0000_0000_0000, NZCV=1001, both write enables 1.
- SUBS reg as CMP, Rd=31: op0=5, op1=5 -> out_data_valid=0, NZCV=0110. With op0=3, op1=5 -> NZCV=1000.
- ADD imm, sh=1, imm12=0x001, op0=0x10 -> out_data=0x1010, out_nzcv_valid=0. Then SBC op0=10, op1=3, C_in=0 -> out_data=6.
- Hold out_ready=0 for 5 cycles while issuing 4 back-to-back ops:
  - fu_ready drops after STAGES accepts.
  - Outputs stay stable while stalled.
  - On release, results emerge in order, one per cycle, with no loss or duplication.
- Inst word 0x0000_0000 -> out_illegal=1, both write enables 0. Asserting rst=0 while 2 ops are in flight -> out_valid=0 next cycle and nothing emerges afterwards.
- With FU_ARITH_PIPE_FLUSH_EN defined: flush with flush_id=4 while ids 3, 4, 5 are in flight -> only id 3 emerges.
